// File: rtl/prio_arb_pkg.sv
// rtl/prio_arb_pkg.sv - shared types and helpers for the priority arbitration fabric
//   NUM_M       : number of masters
//   ID_W        : master index width
//   master_id_t : master index type
//   onehot()    : master index to one-hot master vector
package prio_arb_pkg;

  localparam int NUM_M = 4;
  localparam int ID_W  = 2;

  typedef logic [ID_W-1:0] master_id_t;

  function automatic logic [NUM_M-1:0] onehot(input master_id_t id);
    logic [NUM_M-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rsp_id_fifo.sv
// rtl/rsp_id_fifo.sv - synchronous in-order FIFO of master IDs
//   clk, rst_n : clock, synchronous active-low reset
//   push/wdata : write request and data (taken when not full, or full with a pop)
//   pop/rdata  : read request and head entry (taken when not empty)
//   count      : registered occupancy
//   full/empty : occupancy == DEPTH / occupancy == 0
module rsp_id_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A pop frees the head slot this edge, so a push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/prio_rsp_router.sv
// rtl/prio_rsp_router.sv - steers slave responses back to the requesting master in order
//   clk, rst_n                     : clock, synchronous active-low reset
//   req_fire, req_id               : slave accepted a request from master req_id
//   rsp_valid, rsp_data, rsp_ready : slave response handshake
//   m_rsp_valid, m_rsp_ready       : one-hot per-master response handshake
//   m_rsp_data                     : response data shared by all masters
//   outstanding, id_empty, id_full : ID FIFO occupancy status
//   err_overflow, err_orphan       : sticky error flags
module prio_rsp_router
  import prio_arb_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_fire,
  input  logic [ID_W-1:0]   req_id,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ready,
  output logic [NUM_M-1:0]  m_rsp_valid,
  output logic [DATA_W-1:0] m_rsp_data,
  input  logic [NUM_M-1:0]  m_rsp_ready,
  output logic [CNT_W-1:0]  outstanding,
  output logic              id_empty,
  output logic              id_full,
  output logic              err_overflow,
  output logic              err_orphan
);

  master_id_t        head_id;
  logic              stage_free, pop, push_en;
  logic              stage_valid_q, stage_valid_d;
  master_id_t        stage_id_q, stage_id_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_orphan_q, err_orphan_d;

  rsp_id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_en),
    .wdata (req_id),
    .pop   (pop),
    .rdata (head_id),
    .count (outstanding),
    .full  (id_full),
    .empty (id_empty)
  );

  // Only the selected master's ready can free the stage; others are ignored.
  assign stage_free = !stage_valid_q || m_rsp_ready[stage_id_q];
  // Registered occupancy only: an ID pushed this cycle cannot pair with a response this cycle.
  assign rsp_ready  = !id_empty && stage_free;
  assign pop        = rsp_valid && rsp_ready;
  assign push_en    = req_fire && (!id_full || pop);

  always_comb begin
    stage_valid_d  = stage_valid_q;
    stage_id_d     = stage_id_q;
    stage_data_d   = stage_data_q;
    err_overflow_d = err_overflow_q;
    err_orphan_d   = err_orphan_q;

    if (pop) begin
      stage_valid_d = 1'b1;
      stage_id_d    = head_id;
      stage_data_d  = rsp_data;
    end else if (stage_valid_q && m_rsp_ready[stage_id_q]) begin
      stage_valid_d = 1'b0;
    end

    if (req_fire && !push_en) err_overflow_d = 1'b1;
    if (rsp_valid && id_empty) err_orphan_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid_q  <= 1'b0;
      stage_id_q     <= '0;
      stage_data_q   <= '0;
      err_overflow_q <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      stage_valid_q  <= stage_valid_d;
      stage_id_q     <= stage_id_d;
      stage_data_q   <= stage_data_d;
      err_overflow_q <= err_overflow_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  assign m_rsp_valid  = stage_valid_q ? onehot(stage_id_q) : '0;
  assign m_rsp_data   = stage_data_q;
  assign err_overflow = err_overflow_q;
  assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_prio_rsp_router.sv
// tb/tb_prio_rsp_router.sv - self-checking bench for prio_rsp_router
module tb_prio_rsp_router;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_fire;
  logic [1:0] req_id;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic [3:0] m_rsp_valid;
  logic [7:0] m_rsp_data;
  logic [3:0] m_rsp_ready;
  logic [2:0] outstanding;
  logic       id_empty;
  logic       id_full;
  logic       err_overflow;
  logic       err_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of outstanding IDs plus a one-entry delivery slot.
  logic [1:0] mq[$];
  bit         m_sv;
  logic [1:0] m_sid;
  logic [7:0] m_sdata;
  bit         m_ovf;
  bit         m_orph;
  bit         known = 0;

  prio_rsp_router #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_fire     (req_fire),
    .req_id       (req_id),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .m_rsp_valid  (m_rsp_valid),
    .m_rsp_data   (m_rsp_data),
    .m_rsp_ready  (m_rsp_ready),
    .outstanding  (outstanding),
    .id_empty     (id_empty),
    .id_full      (id_full),
    .err_overflow (err_overflow),
    .err_orphan   (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit f, input logic [1:0] id, input bit rv,
                       input logic [7:0] d, input logic [3:0] mr);
    req_fire    = f;
    req_id      = id;
    rsp_valid   = rv;
    rsp_data    = d;
    m_rsp_ready = mr;
  endtask

  // Compare all outputs against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int         sz;
    bit         free, rdy, pop;
    logic [3:0] ev;
    @(negedge clk);
    sz   = mq.size();
    free = !m_sv || m_rsp_ready[m_sid];
    rdy  = (sz != 0) && free;
    if (known) begin
      ev = m_sv ? (4'b0001 << m_sid) : 4'b0000;
      check("rsp_ready",    rsp_ready,    rdy);
      check("m_rsp_valid",  m_rsp_valid,  ev);
      check("m_rsp_data",   m_rsp_data,   m_sdata);
      check("outstanding",  outstanding,  sz);
      check("id_empty",     id_empty,     sz == 0);
      check("id_full",      id_full,      sz == DEPTH);
      check("err_overflow", err_overflow, m_ovf);
      check("err_orphan",   err_orphan,   m_orph);
    end
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_sv    = 0;
      m_sid   = '0;
      m_sdata = '0;
      m_ovf   = 0;
      m_orph  = 0;
      known   = 1;
    end else if (known) begin
      pop = rsp_valid && rdy;
      if (rsp_valid && sz == 0) m_orph = 1;
      if (pop) begin
        m_sid   = mq.pop_front();
        m_sv    = 1;
        m_sdata = rsp_data;
      end else if (m_sv && m_rsp_ready[m_sid]) begin
        m_sv = 0;
      end
      if (req_fire) begin
        if (sz < DEPTH || pop) mq.push_back(req_id);
        else m_ovf = 1;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1), 8'($urandom), 4'($urandom));
      cycle();
    end
    check("rst_m_rsp_valid", m_rsp_valid, 0);
    check("rst_m_rsp_data",  m_rsp_data,  0);
    check("rst_outstanding", outstanding, 0);
    check("rst_id_empty",    id_empty,    1);
    check("rst_id_full",     id_full,     0);
    check("rst_rsp_ready",   rsp_ready,   0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 4'b1111);
    cycle();

    // In-order routing
    drive(1, 2, 0, 0, 4'b1111); cycle();
    drive(1, 0, 0, 0, 4'b1111); cycle();
    drive(1, 3, 0, 0, 4'b1111); cycle();
    drive(0, 0, 1, 8'hA1, 4'b1111); cycle();
    check("ord0_valid", m_rsp_valid, 4'b0100);
    check("ord0_data",  m_rsp_data,  8'hA1);
    drive(0, 0, 1, 8'hB2, 4'b1111); cycle();
    check("ord1_valid", m_rsp_valid, 4'b0001);
    check("ord1_data",  m_rsp_data,  8'hB2);
    drive(0, 0, 1, 8'hC3, 4'b1111); cycle();
    check("ord2_valid", m_rsp_valid, 4'b1000);
    check("ord2_data",  m_rsp_data,  8'hC3);
    drive(0, 0, 0, 0, 4'b1111); cycle();
    check("ord_outstanding", outstanding, 0);

    // Backpressure
    drive(1, 1, 0, 0, 4'b1101); cycle();
    drive(1, 3, 0, 0, 4'b1101); cycle();
    drive(0, 0, 1, 8'h5A, 4'b1101); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8'h77, 4'b1101);
      #1;
      check("bp_rsp_ready", rsp_ready, 0);
      cycle();
      check("bp_valid", m_rsp_valid, 4'b0010);
      check("bp_data",  m_rsp_data,  8'h5A);
    end
    drive(0, 0, 1, 8'h77, 4'b1111);
    #1;
    check("bp_release_ready", rsp_ready, 1);
    cycle();
    check("bp_next_valid", m_rsp_valid, 4'b1000);
    check("bp_next_data",  m_rsp_data,  8'h77);
    drive(0, 0, 0, 0, 4'b1111); cycle();

    // Full and overflow
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(i), 0, 0, 4'b1111); cycle();
    end
    check("full_flag", id_full, 1);
    check("full_outstanding", outstanding, 4);
    drive(1, 2, 0, 0, 4'b1111); cycle();
    check("ovf_flag", err_overflow, 1);
    check("ovf_outstanding", outstanding, 4);
    drive(1, 3, 1, 8'h11, 4'b1111); cycle();
    check("pushpop_outstanding", outstanding, 4);
    check("pushpop_ovf", err_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 8'(8'h20 + i), 4'b1111); cycle();
    end
    drive(0, 0, 0, 0, 4'b1111); cycle();

    // Orphan response
    drive(0, 0, 1, 8'h3C, 4'b1111);
    #1;
    check("orph_rsp_ready", rsp_ready, 0);
    cycle();
    check("orph_flag", err_orphan, 1);
    drive(1, 2, 1, 8'h3C, 4'b1111); cycle();
    drive(0, 0, 1, 8'h3C, 4'b1111);
    #1;
    check("orph_release_ready", rsp_ready, 1);
    cycle();
    check("orph_valid", m_rsp_valid, 4'b0100);
    check("orph_data",  m_rsp_data,  8'h3C);
    drive(0, 0, 0, 0, 4'b1111); cycle();

    // Reset mid-flight
    drive(1, 0, 0, 0, 4'b0000); cycle();
    drive(1, 1, 0, 0, 4'b0000); cycle();
    drive(1, 2, 0, 0, 4'b0000); cycle();
    drive(0, 0, 1, 8'h44, 4'b0000); cycle();
    drive(0, 0, 0, 0, 4'b0000); cycle();
    check("mid_held_valid", m_rsp_valid, 4'b0001);
    check("mid_outstanding", outstanding, 2);
    rst_n = 1'b0;
    cycle();
    check("mid_rst_valid", m_rsp_valid, 0);
    check("mid_rst_outstanding", outstanding, 0);
    check("mid_rst_ovf", err_overflow, 0);
    check("mid_rst_orph", err_orphan, 0);
    rst_n = 1'b1;
    drive(1, 1, 0, 0, 4'b1111); cycle();
    drive(0, 0, 1, 8'h99, 4'b1111); cycle();
    check("mid_after_valid", m_rsp_valid, 4'b0010);
    check("mid_after_data",  m_rsp_data,  8'h99);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 1), 2'($urandom), $urandom_range(0, 2) != 0, 8'($urandom),
            {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0});
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_rsp_router.md
# prio_rsp_router

Return-path router for the 4-master/1-slave priority arbitration fabric. It records the master ID of every request the slave accepts in an in-order ID FIFO. Each slave response is then steered to the master that issued the matching request, through a registered one-entry output stage with a per-master valid/ready handshake. It sits between the slave's response port and the four masters, opposite the request-side priority arbiter.

## Interface
Parameters:
- DATA_W, 8, response data width
- DEPTH, 4, maximum outstanding requests (power of two, ≥2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_fire  in  1  slave accepted a request this cycle
- req_id  in  2  master index (0-3) of the accepted request
- rsp_valid  in  1  slave response valid
- rsp_data  in  DATA_W  slave response data
- rsp_ready  out  1  router accepts the slave response
- m_rsp_valid  out  4  one-hot response valid, bit i = master i
- m_rsp_data  out  DATA_W  response data, shared by all masters
- m_rsp_ready  in  4  per-master ready
- outstanding  out  $clog2(DEPTH+1)  current ID FIFO occupancy
- id_empty  out  1  occupancy == 0
- id_full  out  1  occupancy == DEPTH
- err_overflow  out  1  sticky: a push was dropped
- err_orphan  out  1  sticky: response arrived with no outstanding ID

## Operation
- Push: on req_fire, req_id is written to the ID FIFO if `!id_full`, or if `id_full` and a pop happens in the same cycle. Otherwise the push is dropped and err_overflow is set.
- Output stage: one register holding data, ID and a valid bit.
  - It is free when empty, or when it is valid and `m_rsp_ready[id]` is 1 this cycle.
- Accept condition: `rsp_ready = !id_empty && stage_free`. This uses only registered occupancy; an ID pushed in cycle N cannot pair with a response in cycle N.
- Pop: on `rsp_valid && rsp_ready`, the head ID is popped. rsp_data and the ID are loaded into the stage, and `m_rsp_valid` becomes onehot(ID).
- Drain: when `m_rsp_valid[i] && m_rsp_ready[i]`, the stage clears, unless a new load happens in the same cycle.
  - Ready bits of non-selected masters are ignored.
- Orphan: `rsp_valid && id_empty` sets err_orphan. rsp_ready stays 0 and the response waits.
- Occupancy: push only → +1; pop only → −1; push and pop together → unchanged. Read and write pointers wrap modulo DEPTH.
- Flags: err_overflow and err_orphan clear only on reset.
- Ordering: responses reach masters strictly in request-acceptance order; there is no reordering.

## Timing
- Reset (rst_n low at a clk edge) clears everything on that edge:
  - FIFO, pointers, output stage, both error flags.
  - rsp_ready=0, m_rsp_valid=0, m_rsp_data=0, outstanding=0, id_empty=1, id_full=0.
- Reset mid-operation discards outstanding IDs and any held response; no partial delivery.
- Latency: response accepted at edge N → m_rsp_valid/m_rsp_data valid after edge N (cycle N+1).
- Throughput: one response per cycle while the selected master holds ready and IDs are available.
- While `m_rsp_valid[i]=1` and `m_rsp_ready[i]=0`: m_rsp_valid and m_rsp_data stay stable, and rsp_ready=0.
- id_full, id_empty, outstanding and the error flags are registered and update one edge after the causing event.
- All state changes are synchronous to clk; there are no combinational paths from m_rsp_ready to m_rsp_valid.

## Structure
- Package prio_arb_pkg holds:
  - NUM_M = 4 and ID_W = 2
  - typedef logic [ID_W-1:0] master_id_t
  - function onehot(master_id_t) returning logic [NUM_M-1:0]
- Sub-module rsp_id_fifo: synchronous FIFO with DEPTH/width parameters, simultaneous push/pop, full/empty/count outputs.
- Top level contains the output stage, the accept logic and the error flags.

## Test plan
- Reset: hold rst_n=0 with random inputs for 3 cycles → all outputs at reset values, id_empty=1, outstanding=0.
- In-order routing: push IDs 2,0,3, then responses 0xA1,0xB2,0xC3 with all ready=1 → m_rsp_valid 0100/0xA1, 0001/0xB2, 1000/0xC3 on consecutive cycles, each one cycle after acceptance; outstanding ends at 0.
- Backpressure: ID 1 outstanding, response 0x5A, m_rsp_ready=1101 for 3 cycles → m_rsp_valid=0010 and data 0x5A held stable, rsp_ready=0. After ready[1]=1, the stage drains and the next response is accepted in that same cycle.
- Full/overflow: 4 pushes with no responses → id_full=1, outstanding=4. A 5th push alone → dropped, err_overflow=1, outstanding=4. Push and pop together at full → accepted, outstanding=4, err_overflow unchanged.
- Orphan: rsp_valid=1 with the FIFO empty → rsp_ready=0, err_orphan=1 next cycle. A later push lets the response through to that ID.
- Reset mid-flight: 2 IDs outstanding plus a held output, then rst_n=0 for 1 cycle → m_rsp_valid=0, outstanding=0, flags clear. The next push/response pair routes correctly.
